// File: rtl/pc_predict_pkg.sv
// Shared types and helpers for the fetch-PC predictor: control-flow kinds and
// 2-bit saturating counter encodings.
package pc_predict_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BR   = 2'b01,
    JAL  = 2'b10,
    JALR = 2'b11
  } ctrl_kind_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] cnt_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'b01;
  endfunction

  function automatic logic [1:0] cnt_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: one combinational lookup port for the
// fetch PC and one edge-triggered update port driven by EX resolution.
module btb_table
  import pc_predict_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // Word addresses (pc[XLEN-1:2]); byte offset plays no part in index or tag
  input  logic [XLEN-3:0] lookup_word_i,
  output logic            lookup_taken_o,
  output logic [XLEN-1:0] lookup_target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-3:0] upd_word_i,
  input  logic            upd_taken_i,
  input  logic            upd_jump_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       cnt;
  } btb_entry_t;

  btb_entry_t       mem_q [BTB_ENTRIES];

  logic [IDX-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_entry, up_entry;
  logic             lk_hit, up_hit;
  logic [1:0]       taken_cnt;

  assign lk_idx   = lookup_word_i[IDX-1:0];
  assign lk_tag   = lookup_word_i[XLEN-3:IDX];
  assign lk_entry = mem_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

  assign lookup_taken_o  = lk_hit && lk_entry.cnt[1];
  assign lookup_target_o = lk_entry.target;

  assign up_idx   = upd_word_i[IDX-1:0];
  assign up_tag   = upd_word_i[XLEN-3:IDX];
  assign up_entry = mem_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  // Unconditional jumps go straight to strongly taken; a fresh allocation
  // (including eviction of an alias) starts weakly taken.
  assign taken_cnt = upd_jump_i ? ST : (up_hit ? cnt_inc(up_entry.cnt) : WT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
      end
    end else if (upd_en_i) begin
      if (upd_taken_i) begin
        mem_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target_i, cnt: taken_cnt};
      end else if (up_hit) begin
        mem_q[up_idx].cnt <= cnt_dec(up_entry.cnt);
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// IF-stage next-PC unit: registered fetch PC, BTB prediction, EX redirect on
// mispredict, trap vectoring, stall hold and a saturating mispredict counter.
module pc_predict_unit
  import pc_predict_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     BTB_ENTRIES  = 16,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = '0,
  parameter int unsigned     CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             invalid_i,
  input  logic             ex_valid_i,
  input  logic [1:0]       ex_kind_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             ex_taken_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  ex_pred_target_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_plus4_o,
  output logic             pred_taken_o,
  output logic [XLEN-1:0]  pred_target_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;
  logic [XLEN-1:0]  btb_target;
  logic             btb_taken;
  ctrl_kind_e       ex_kind;
  logic             ex_resolve;
  logic             ex_jump;
  logic             mp;

  assign ex_kind    = ctrl_kind_e'(ex_kind_i);
  assign ex_resolve = ex_valid_i && (ex_kind != NONE);
  assign ex_jump    = (ex_kind == JAL) || (ex_kind == JALR);

  btb_table #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .lookup_word_i   (pc_q[XLEN-1:2]),
    .lookup_taken_o  (btb_taken),
    .lookup_target_o (btb_target),
    .upd_en_i        (ex_resolve),
    .upd_word_i      (ex_pc_i[XLEN-1:2]),
    .upd_taken_i     (ex_taken_i),
    .upd_jump_i      (ex_jump),
    .upd_target_i    (ex_target_i)
  );

  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + XLEN'(4);
  assign pred_taken_o  = btb_taken;
  assign pred_target_o = btb_taken ? btb_target : pc_plus4_o;

  // Target is only compared when the branch really went, since a not-taken
  // prediction carries no meaningful target.
  assign mp = ex_resolve &&
              ((ex_taken_i != ex_pred_taken_i) ||
               (ex_taken_i && (ex_target_i != ex_pred_target_i)));

  always_comb begin
    pc_d    = pred_target_o;
    flush_o = 1'b0;
    if (invalid_i) begin
      pc_d    = TRAP_VECTOR;
      flush_o = 1'b1;
    end else if (mp) begin
      pc_d    = ex_taken_i ? ex_target_i : ex_pc_i + XLEN'(4);
      flush_o = 1'b1;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  assign mp_cnt_d = (mp && !(&mp_cnt_q)) ? mp_cnt_q + CNT_W'(1) : mp_cnt_q;
  assign mispredict_cnt_o = mp_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_VECTOR;
      mp_cnt_q <= '0;
    end else begin
      pc_q     <= pc_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios plus randomized traffic, all
// checked against an arithmetic model of the fetch PC, BTB and counter.
module tb_pc_predict_unit;

  localparam int unsigned E    = 4;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] TV   = 32'h0000_0080;
  localparam int unsigned CMAX = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, inv = 1'b0, exv = 1'b0, extk = 1'b0, expt = 1'b0;
  logic [1:0]  kind = 2'b00;
  logic [31:0] expc = '0, extgt = '0, exptg = '0;

  logic [31:0] pc_o, pc_plus4_o, pred_target_o;
  logic        pred_taken_o, flush_o;
  logic [3:0]  mpc_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  int unsigned m_mpc;
  bit          m_valid [E];
  logic [31:0] m_tag   [E];
  logic [31:0] m_tgt   [E];
  int          m_cnt   [E];
  bit          exp_pt, exp_flush;
  logic [31:0] exp_ptg;

  pc_predict_unit #(
    .XLEN         (32),
    .BTB_ENTRIES  (E),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .CNT_W        (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .invalid_i        (inv),
    .ex_valid_i       (exv),
    .ex_kind_i        (kind),
    .ex_pc_i          (expc),
    .ex_taken_i       (extk),
    .ex_target_i      (extgt),
    .ex_pred_taken_i  (expt),
    .ex_pred_target_i (exptg),
    .pc_o             (pc_o),
    .pc_plus4_o       (pc_plus4_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .flush_o          (flush_o),
    .mispredict_cnt_o (mpc_o)
  );

  always #5 clk = ~clk;

  function automatic bit model_mp();
    return exv && (kind != 2'b00) && ((extk != expt) || (extk && (extgt != exptg)));
  endfunction

  function automatic void model_pred(output bit pt, output logic [31:0] tg);
    int unsigned i = (m_pc / 4) % E;
    logic [31:0] t = m_pc / (4 * E);
    pt = m_valid[i] && (m_tag[i] == t) && (m_cnt[i] >= 2);
    tg = pt ? m_tgt[i] : m_pc + 32'd4;
  endfunction

  function automatic void model_reset();
    m_pc  = RV;
    m_mpc = 0;
    for (int i = 0; i < int'(E); i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_cnt[i]   = 1;
    end
  endfunction

  // Apply inputs just after an edge and compute the expected combinational outputs.
  task automatic drive(input bit s, input bit iv, input bit v, input logic [1:0] k,
                       input logic [31:0] p, input bit tk, input logic [31:0] tg,
                       input bit ptk, input logic [31:0] ptg);
    stall = s; inv = iv; exv = v; kind = k; expc = p;
    extk = tk; extgt = tg; expt = ptk; exptg = ptg;
    #1;
    model_pred(exp_pt, exp_ptg);
    exp_flush = iv || model_mp();
  endtask

  task automatic idle(input bit s);
    drive(s, 0, 0, 2'b00, '0, 0, '0, 0, '0);
  endtask

  // Advance the model and the DUT by one clock edge.
  task automatic tick();
    bit          mp;
    bit          pt;
    logic [31:0] ptg;
    logic [31:0] npc;
    int unsigned i;
    logic [31:0] t;
    bit          hit;
    mp = model_mp();
    model_pred(pt, ptg);
    if (inv)        npc = TV;
    else if (mp)    npc = extk ? extgt : expc + 32'd4;
    else if (stall) npc = m_pc;
    else            npc = ptg;
    if (exv && kind != 2'b00) begin
      i   = (expc / 4) % E;
      t   = expc / (4 * E);
      hit = m_valid[i] && (m_tag[i] == t);
      if (extk) begin
        if (kind >= 2'b10) m_cnt[i] = 3;
        else if (hit)      m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        else               m_cnt[i] = 2;
        m_valid[i] = 1'b1;
        m_tag[i]   = t;
        m_tgt[i]   = extgt;
      end else if (hit) begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end
    if (mp && m_mpc < CMAX) m_mpc++;
    @(posedge clk);
    m_pc = npc;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stall = 0; inv = 0; exv = 0; kind = 2'b00;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] want;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    stall = 0; inv = 0; exv = 0; kind = 2'b00;
    model_reset();
    #1;
    n_vec++;
    if (pc_o !== RV) begin
      n_err++; $display("FAIL reset_pc: got %h expected %h", pc_o, RV);
    end
    n_vec++;
    if (mpc_o !== 4'd0) begin
      n_err++; $display("FAIL reset_mpc: got %0d expected 0", mpc_o);
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      idle(0);
      want = 32'(c * 4);
      n_vec++;
      if (pc_o !== want || pred_taken_o !== 1'b0 || flush_o !== 1'b0) begin
        n_err++;
        $display("FAIL reset_seq: got pc %h pt %b fl %b expected pc %h pt 0 fl 0",
                 pc_o, pred_taken_o, flush_o, want);
      end
      tick();
    end
  endtask

  task automatic test_learning();
    do_reset();
    drive(0, 0, 1, 2'b01, 32'h10, 1, 32'h40, 0, 32'h0);
    n_vec++;
    if (flush_o !== 1'b1) begin
      n_err++; $display("FAIL learn_flush: got %b expected 1", flush_o);
    end
    tick();
    n_vec++;
    if (pc_o !== 32'h40 || mpc_o !== 4'd1) begin
      n_err++; $display("FAIL learn_redirect: got pc %h cnt %0d expected pc 40 cnt 1", pc_o, mpc_o);
    end
    // Not-taken resolution at 0x0C predicted taken steers fetch back to 0x10
    drive(0, 0, 1, 2'b01, 32'h0C, 0, 32'h0, 1, 32'h99);
    tick();
    idle(1);
    n_vec++;
    if (pc_o !== 32'h10 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h40) begin
      n_err++;
      $display("FAIL learn_predict: got pc %h pt %b tgt %h expected pc 10 pt 1 tgt 40",
               pc_o, pred_taken_o, pred_target_o);
    end
    drive(1, 0, 1, 2'b01, 32'h10, 1, 32'h40, 1, 32'h40);
    n_vec++;
    if (flush_o !== 1'b0) begin
      n_err++; $display("FAIL learn_correct: got flush %b expected 0", flush_o);
    end
    tick();
    // Walk the counter 11 -> 10 -> 01 -> 00 -> 00, then one taken -> 01
    for (int s = 0; s < 4; s++) begin
      drive(1, 0, 1, 2'b01, 32'h10, 0, 32'h0, 0, 32'h0);
      tick();
      idle(1);
      n_vec++;
      if (pred_taken_o !== exp_pt || pred_taken_o !== (s == 0)) begin
        n_err++;
        $display("FAIL hysteresis_%0d: got pt %b expected %b", s, pred_taken_o, s == 0);
      end
    end
    drive(1, 0, 1, 2'b01, 32'h10, 1, 32'h40, 1, 32'h40);
    tick();
    idle(1);
    n_vec++;
    if (pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL no_wrap: got pt %b expected 0", pred_taken_o);
    end
  endtask

  task automatic test_jalr();
    do_reset();
    drive(0, 0, 1, 2'b11, 32'h20, 1, 32'h100, 0, 32'h0);
    tick();
    drive(0, 0, 1, 2'b11, 32'h20, 1, 32'h200, 1, 32'h100);
    n_vec++;
    if (flush_o !== 1'b1) begin
      n_err++; $display("FAIL jalr_flush: got %b expected 1", flush_o);
    end
    tick();
    n_vec++;
    if (pc_o !== 32'h200) begin
      n_err++; $display("FAIL jalr_pc: got %h expected 200", pc_o);
    end
    drive(0, 0, 1, 2'b01, 32'h1C, 0, 32'h0, 1, 32'h5);
    tick();
    idle(0);
    n_vec++;
    if (pc_o !== 32'h20 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin
      n_err++;
      $display("FAIL jalr_btb: got pc %h pt %b tgt %h expected pc 20 pt 1 tgt 200",
               pc_o, pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    idle(0);
    tick();
    idle(1);
    tick();
    n_vec++;
    if (pc_o !== 32'h4) begin
      n_err++; $display("FAIL stall_hold: got %h expected 4", pc_o);
    end
    drive(1, 0, 1, 2'b01, 32'h30, 1, 32'h60, 0, 32'h0);
    tick();
    n_vec++;
    if (pc_o !== 32'h60 || mpc_o !== 4'd1) begin
      n_err++; $display("FAIL stall_mp: got pc %h cnt %0d expected pc 60 cnt 1", pc_o, mpc_o);
    end
    drive(1, 1, 1, 2'b01, 32'h34, 1, 32'h90, 0, 32'h0);
    n_vec++;
    if (flush_o !== 1'b1) begin
      n_err++; $display("FAIL trap_flush: got %b expected 1", flush_o);
    end
    tick();
    n_vec++;
    if (pc_o !== TV || mpc_o !== 4'd2) begin
      n_err++; $display("FAIL trap_pc: got pc %h cnt %0d expected pc %h cnt 2", pc_o, mpc_o, TV);
    end
  endtask

  task automatic test_alias();
    do_reset();
    drive(0, 0, 1, 2'b01, 32'h10, 1, 32'h40, 0, 32'h0);
    tick();
    drive(0, 0, 1, 2'b01, 32'h20, 1, 32'h50, 0, 32'h0);
    tick();
    drive(0, 0, 1, 2'b01, 32'h0C, 0, 32'h0, 1, 32'h7);
    tick();
    idle(0);
    n_vec++;
    if (pc_o !== 32'h10 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h14) begin
      n_err++;
      $display("FAIL alias_evict: got pc %h pt %b tgt %h expected pc 10 pt 0 tgt 14",
               pc_o, pred_taken_o, pred_target_o);
    end
    drive(0, 0, 1, 2'b01, 32'h1C, 0, 32'h0, 1, 32'h7);
    tick();
    idle(0);
    n_vec++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h50) begin
      n_err++; $display("FAIL alias_keep: got pt %b tgt %h expected pt 1 tgt 50",
                        pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 20; n++) begin
      drive(0, 0, 1, 2'b01, 32'($urandom_range(0, 63) * 4), 1,
            32'($urandom_range(0, 63) * 4), 0, 32'h0);
      tick();
      n_vec++;
      if (mpc_o !== 4'(m_mpc)) begin
        n_err++; $display("FAIL sat_step_%0d: got %0d expected %0d", n, mpc_o, m_mpc);
      end
    end
    n_vec++;
    if (mpc_o !== 4'd15) begin
      n_err++; $display("FAIL sat_final: got %0d expected 15", mpc_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 0, 1, 2'b01, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    tick();
    n_vec++;
    if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
      n_err++; $display("FAIL wrap_plus4: got pc %h p4 %h expected pc fffffffc p4 0",
                        pc_o, pc_plus4_o);
    end
    idle(0);
    tick();
    n_vec++;
    if (pc_o !== 32'h0) begin
      n_err++; $display("FAIL wrap_next: got %h expected 0", pc_o);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 1, 2'b01, 32'h0, 1, 32'h44, 0, 32'h0);
    tick();
    rst_n = 1'b0;
    stall = 0; inv = 0; exv = 0; kind = 2'b00;
    #1;
    n_vec++;
    if (pc_o !== RV || mpc_o !== 4'd0) begin
      n_err++; $display("FAIL async_reset: got pc %h cnt %0d expected pc %h cnt 0",
                        pc_o, mpc_o, RV);
    end
    model_reset();
    #1;
    rst_n = 1'b1;
    idle(0);
    n_vec++;
    if (pc_o !== RV || pred_taken_o !== 1'b0) begin
      n_err++; $display("FAIL async_btb_clear: got pc %h pt %b expected pc %h pt 0",
                        pc_o, pred_taken_o, RV);
    end
    tick();
    n_vec++;
    if (pc_o !== RV + 32'd4) begin
      n_err++; $display("FAIL async_first_fetch: got %h expected %h", pc_o, RV + 32'd4);
    end
  endtask

  task automatic test_random();
    logic [1:0]  k;
    logic [31:0] p, tg, ptg;
    bit          tk, ptk;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      k   = 2'($urandom_range(0, 3));
      p   = 32'($urandom_range(0, 31) * 4);
      tg  = 32'($urandom_range(0, 31) * 4);
      tk  = (k >= 2'b10) ? 1'b1 : 1'($urandom_range(0, 1));
      ptk = 1'($urandom_range(0, 1));
      ptg = ($urandom_range(0, 2) != 0) ? tg : 32'($urandom_range(0, 31) * 4);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, k, p, tk, tg, ptk, ptg);
      n_vec++;
      if (pred_taken_o !== exp_pt || pred_target_o !== exp_ptg || flush_o !== exp_flush) begin
        n_err++;
        $display("FAIL rand_comb_%0d: got pt %b tgt %h fl %b expected pt %b tgt %h fl %b",
                 n, pred_taken_o, pred_target_o, flush_o, exp_pt, exp_ptg, exp_flush);
      end
      tick();
      n_vec++;
      if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4 || mpc_o !== 4'(m_mpc)) begin
        n_err++;
        $display("FAIL rand_state_%0d: got pc %h p4 %h cnt %0d expected pc %h p4 %h cnt %0d",
                 n, pc_o, pc_plus4_o, mpc_o, m_pc, m_pc + 32'd4, m_mpc);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_learning();
    test_jalr();
    test_stall();
    test_alias();
    test_saturation();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
